async_fifo_rd_ptr_ctrl: RTL

Read-domain pointer controller for the async FIFO. Synchronizes the write-domain Gray pointer into the read clock and decodes it to binary. Owns the read binary pointer and publishes the registered read Gray pointer back to the write domain. Produces the empty flag, read occupancy count, read address and underflow indication for the FIFO memory read port.

---
 rtl/async_fifo_rd_ptr_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/async_fifo_rd_ptr_ctrl.sv
// async_fifo_rd_ptr_ctrl: read-side pointer, empty/count and write-pointer sync for an async FIFO.
// Optional Gray-sequence checker on the synchronized write pointer: ASYNC_FIFO_GRAY_CHECK_EN.
module async_fifo_rd_ptr_ctrl #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [ADDR_WIDTH:0]   wptr_gray_async,
    input  logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow,
    output logic                  gray_err
);
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
    logic [ADDR_WIDTH:0] wq, wbin;
    logic [ADDR_WIDTH:0] rbin_q, rbin_d, rgray_q, gnext, count_q, count_d;
    logic                empty_q, underflow_q, rd_fire;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= wptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign wq = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) wbin[i] = ^(wq >> i);
    end

    always_comb begin
        rd_fire = rd_en & ~empty_q;
        rbin_d  = rd_fire ? rbin_q + ONE : rbin_q;
        gnext   = rbin_d ^ (rbin_d >> 1);
        count_d = wbin - rbin_d;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            empty_q     <= 1'b1;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= gnext;
            empty_q     <= (gnext == wq);
            count_q     <= count_d;
            underflow_q <= rd_en & empty_q;
        end
    end

    assign rd_addr   = rbin_q[ADDR_WIDTH-1:0];
    assign rptr_gray = rgray_q;
    assign empty     = empty_q;
    assign rd_count  = count_q;
    assign underflow = underflow_q;

`ifdef ASYNC_FIFO_GRAY_CHECK_EN
    logic [ADDR_WIDTH:0] wq_prev_q, wq_diff;
    logic                gray_err_q, multi_bit;

    // More than one bit set in the step means the source was not a legal Gray sequence.
    always_comb begin
        wq_diff   = wq ^ wq_prev_q;
        multi_bit = |(wq_diff & (wq_diff - ONE));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wq_prev_q  <= '0;
            gray_err_q <= 1'b0;
        end else begin
            wq_prev_q  <= wq;
            gray_err_q <= gray_err_q | multi_bit;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge rclk) begin
        if (rrst_n && multi_bit) $error("gray step violation: %b -> %b", wq_prev_q, wq);
    end
`endif

    assign gray_err = gray_err_q;
`else
    assign gray_err = 1'b0;
`endif
endmodule
